// File: rtl/avmm_mem_responder_if.sv
// Avalon-MM style request/response bus between an initiator and the memory responder.
// The initiator drives the request fields; the responder drives data, handshake and error back.
interface avmm_mem_responder_if #(
    parameter int DATA_WIDTH = 64
);
    logic [31:0]           address;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic                  waitrequest;
    logic                  err;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid, waitrequest, err
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid, waitrequest, err
    );
endinterface

// File: rtl/avmm_mem_responder.sv
// Word-addressed memory responder: zero-fills its storage after reset, then serves pipelined
// reads with fixed latency and in-order responses, throttled by a bound on outstanding reads.
module avmm_mem_responder #(
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH       = 16,
    parameter int LATENCY     = 2,
    parameter int MAX_PENDING = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    avmm_mem_responder_if.slave bus
);
    localparam int AW         = $clog2(DEPTH);
    localparam int IW         = AW + 1;
    localparam int PW         = $clog2(MAX_PENDING + 1);
    localparam int BEEF_WORDS = (DATA_WIDTH + 31) / 32;
    localparam logic [BEEF_WORDS*32-1:0] BEEF_WIDE = {BEEF_WORDS{32'hDEAD_BEEF}};
    localparam logic [DATA_WIDTH-1:0]    OOR_DATA  = BEEF_WIDE[DATA_WIDTH-1:0];

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [IW-1:0]         init_idx;
    logic                  init_done;
    logic [PW-1:0]         pending;
    logic                  waitrequest;
    logic                  accept;
    logic                  accept_rd;
    logic                  accept_wr;
    logic                  in_range;
    logic                  proto_err;
    logic                  load_out;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [LATENCY-1:0]    pipe_vld;
    logic [DATA_WIDTH-1:0] pipe_data [LATENCY];
    logic [LATENCY-1:0]    stage_in_vld;
    logic [DATA_WIDTH-1:0] stage_in_data [LATENCY];

    assign init_done = (init_idx == IW'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        waitrequest = 1'b1;
        case (state)
            INIT: begin
                if (init_done) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                waitrequest = !rst_n || (pending == PW'(MAX_PENDING));
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_idx <= '0;
        end else if (state == INIT && !init_done) begin
            init_idx <= init_idx + IW'(1);
        end
    end

    assign in_range  = (bus.address < 32'(DEPTH));
    assign accept    = (state == READY) && !waitrequest && (bus.read || bus.write);
    assign accept_rd = accept && bus.read;
    // A simultaneous read and write is serviced as a read; the write half is dropped.
    assign accept_wr = accept && bus.write && !bus.read;
    assign proto_err = accept && (!in_range || (bus.read && bus.write));
    assign rd_word   = in_range ? mem[bus.address[AW-1:0]] : OOR_DATA;

    // NOTE: storage carries no reset; the INIT sweep zeroes it one word per cycle instead.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            if (!init_done) begin
                mem[init_idx[AW-1:0]] <= '0;
            end
        end else if (accept_wr && in_range) begin
            mem[bus.address[AW-1:0]] <= bus.writedata;
        end
    end

    assign stage_in_vld[0]  = accept_rd;
    assign stage_in_data[0] = rd_word;
    for (genvar i = 1; i < LATENCY; i++) begin : g_stage
        assign stage_in_vld[i]  = pipe_vld[i-1];
        assign stage_in_data[i] = pipe_data[i-1];
    end

    // Each stage holds its data while no new entry arrives, so readdata keeps its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld <= stage_in_vld;
            for (int i = 0; i < LATENCY; i++) begin
                if (stage_in_vld[i]) begin
                    pipe_data[i] <= stage_in_data[i];
                end
            end
        end
    end

    // pending counts reads not yet loaded into the output register, so a full pipe of
    // LATENCY back-to-back reads never reaches MAX_PENDING when MAX_PENDING >= LATENCY.
    assign load_out = stage_in_vld[LATENCY-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (accept_rd && !load_out) begin
            pending <= pending + PW'(1);
        end else if (!accept_rd && load_out) begin
            pending <= pending - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (proto_err) begin
            err_q <= 1'b1;
        end
    end

    assign bus.readdata      = pipe_data[LATENCY-1];
    assign bus.readdatavalid = pipe_vld[LATENCY-1];
    assign bus.waitrequest   = waitrequest;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_avmm_mem_responder.sv
// Self-checking bench: reset/init timing, a vector table, throttling, error and reset-abort
// sequences, and a randomized phase scored against a queue-based memory model.
module tb_avmm_mem_responder;
    localparam int          DW    = 64;
    localparam int          DEPTH = 16;
    localparam int          LAT   = 2;
    localparam int          NVEC  = 20;
    localparam logic [63:0] BEEF  = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    avmm_mem_responder_if #(.DATA_WIDTH(DW)) bus0 ();
    avmm_mem_responder_if #(.DATA_WIDTH(DW)) bus1 ();

    avmm_mem_responder #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT), .MAX_PENDING(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    avmm_mem_responder #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(3), .MAX_PENDING(1)
    ) u_thr (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          due;
        logic [63:0] data;
    } resp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;
    logic        s_rdv, s_wait, s_err;
    logic [63:0] s_rdata;
    logic        t_rdv, t_wait;
    logic [63:0] t_rdata;
    logic [63:0] mem_m [DEPTH];
    logic        err_m;
    resp_t       exp_q [$];
    vec_t        vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: responses are due LAT cycles after acceptance, in acceptance order.
    task automatic model_eval();
        resp_t r;
        logic  exp_rdv;
        exp_rdv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("rnd_rdv", s_rdv, exp_rdv);
        if (exp_rdv) begin
            check("rnd_data", s_rdata, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        check("rnd_err", s_err, err_m);
        check("rnd_wait", s_wait, 1'b0);
        if ((bus0.read || bus0.write) && !s_wait) begin
            if (bus0.read) begin
                r.due  = cyc + LAT;
                r.data = (bus0.address < DEPTH) ? mem_m[bus0.address[3:0]] : BEEF;
                exp_q.push_back(r);
                if (bus0.write || bus0.address >= DEPTH) err_m = 1'b1;
            end else if (bus0.address < DEPTH) begin
                mem_m[bus0.address[3:0]] = bus0.writedata;
            end else begin
                err_m = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        s_rdv   = bus0.readdatavalid;
        s_rdata = bus0.readdata;
        s_wait  = bus0.waitrequest;
        s_err   = bus0.err;
        t_rdv   = bus1.readdatavalid;
        t_rdata = bus1.readdata;
        t_wait  = bus1.waitrequest;
        if (mon_en) model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [63:0] d);
        bus0.read      = rd;
        bus0.write     = wr;
        bus0.address   = a;
        bus0.writedata = d;
    endtask

    // Release reset right after an edge and check the INIT window: busy for DEPTH+1 cycles.
    task automatic init_window(input string name);
        rst_n = 1'b1;
        for (int c = 0; c <= DEPTH; c++) begin
            tick();
            check({name, "_wait_init"}, s_wait, 1'b1);
            check({name, "_rdv_init"}, s_rdv, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int op;
        for (int i = 0; i < 9; i++) begin
            vecs[i]     = '{rd: 1'b0, wr: 1'b1, addr: 32'(i), wdata: 64'(16 + i),
                            exp_data: 64'h0, exp_err: 1'b0};
            vecs[i + 9] = '{rd: 1'b1, wr: 1'b0, addr: 32'(i), wdata: 64'h0,
                            exp_data: 64'(16 + i), exp_err: 1'b0};
        end
        vecs[18] = '{rd: 1'b0, wr: 1'b1, addr: 32'd5, wdata: 64'h0123_4567_89AB_CDEF,
                     exp_data: 64'h0, exp_err: 1'b0};
        vecs[19] = '{rd: 1'b1, wr: 1'b0, addr: 32'd5, wdata: 64'h0,
                     exp_data: 64'h0123_4567_89AB_CDEF, exp_err: 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 64'h0);
        bus1.read = 1'b0; bus1.write = 1'b0; bus1.address = '0; bus1.writedata = '0;
        repeat (3) tick();
        check("rst_rdv", s_rdv, 1'b0);
        check("rst_rdata", s_rdata, 64'h0);
        check("rst_err", s_err, 1'b0);
        check("rst_wait", s_wait, 1'b1);
        check("rst_thr_wait", t_wait, 1'b1);

        // Read held at addr 3 through INIT: accepted in cycle DEPTH+1, data two cycles later.
        drive(1'b1, 1'b0, 32'd3, 64'h0);
        init_window("boot");
        check("boot_thr_wait_init", t_wait, 1'b1);
        tick();
        check("boot_wait_ready", s_wait, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 64'h0);
        tick();
        check("boot_rdv_early", s_rdv, 1'b0);
        tick();
        check("boot_rdv", s_rdv, 1'b1);
        check("boot_rdata", s_rdata, 64'h0);

        for (int j = 0; j < NVEC + LAT; j++) begin
            if (j < NVEC) drive(vecs[j].rd, vecs[j].wr, vecs[j].addr, vecs[j].wdata);
            else          drive(1'b0, 1'b0, 32'h0, 64'h0);
            tick();
            if (j < NVEC) check("tbl_wait", s_wait, 1'b0);
            if (j >= LAT) begin
                check("tbl_rdv", s_rdv, vecs[j - LAT].rd);
                if (vecs[j - LAT].rd) check("tbl_rdata", s_rdata, vecs[j - LAT].exp_data);
            end else begin
                check("tbl_rdv", s_rdv, 1'b0);
            end
            if (j >= 1) check("tbl_err", s_err, vecs[j - 1].exp_err);
        end
        tick();
        check("tbl_rdata_hold", s_rdata, 64'h0123_4567_89AB_CDEF);

        // MAX_PENDING=1, LATENCY=3: one acceptance every third cycle.
        acc = 0;
        bus1.read = 1'b1; bus1.address = 32'd7;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("thr_wait", t_wait, (k % 3) != 0);
            check("thr_rdv", t_rdv, (k % 3 == 0) && (k >= 3));
            if (t_rdv) check("thr_rdata", t_rdata, 64'h0);
            if (!t_wait) acc++;
        end
        bus1.read = 1'b0;
        check("thr_accepts", acc, 4);

        // Out-of-range read, then read+write collision at addr 2.
        drive(1'b1, 1'b0, 32'd20, 64'h0);
        tick();
        check("oor_wait", s_wait, 1'b0);
        check("oor_err_before", s_err, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 64'h0);
        tick();
        check("oor_err", s_err, 1'b1);
        check("oor_rdv_early", s_rdv, 1'b0);
        tick();
        check("oor_rdv", s_rdv, 1'b1);
        check("oor_rdata", s_rdata, BEEF);
        drive(1'b1, 1'b1, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        drive(1'b1, 1'b0, 32'd2, 64'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 64'h0);
        tick();
        check("rw_rdv", s_rdv, 1'b1);
        check("rw_rdata", s_rdata, 64'h12);
        tick();
        check("rw_after_rdv", s_rdv, 1'b1);
        check("rw_after_rdata", s_rdata, 64'h12);
        check("err_sticky", s_err, 1'b1);

        // Randomized traffic against the model after a fresh reset.
        rst_n = 1'b0;
        repeat (2) tick();
        init_window("rnd");
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        err_m = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(0, 15);
            if (k < 150 && op == 12) op = 13;
            drive(op <= 5 || op == 12, (op >= 6 && op <= 12),
                  (k >= 150 && $urandom_range(0, 19) == 0) ? 32'($urandom_range(16, 40))
                                                            : 32'($urandom_range(0, 15)),
                  {$urandom, $urandom});
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 64'h0);
        repeat (4) tick();
        mon_en = 1'b0;
        check("rnd_drain", exp_q.size(), 0);

        // Reset with reads in flight: nothing returns, INIT restarts.
        drive(1'b1, 1'b0, 32'd1, 64'h0);
        tick();
        drive(1'b1, 1'b0, 32'd2, 64'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 64'h0);
        rst_n = 1'b0;
        tick();
        init_window("abort");
        tick();
        check("abort_wait_ready", s_wait, 1'b0);
        check("abort_rdv", s_rdv, 1'b0);
        check("abort_rdata", s_rdata, 64'h0);
        check("abort_err", s_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
